// File: rtl/washer_pkg.sv
// Shared definitions for the washing-machine controller and its plant emulator:
// controller state codes, selector codes, fault bit indices and rate-counter modes.
package washer_pkg;

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    WATER_FILLING  = 3'd1,
    WATER_HEATING  = 3'd2,
    WASHING        = 3'd3,
    WATER_DRAINING = 3'd4
  } ctrl_state_e;

  typedef enum logic [1:0] {
    SEL_0 = 2'b00,
    SEL_1 = 2'b01,
    SEL_2 = 2'b10,
    SEL_3 = 2'b11
  } selector_e;

  localparam int FLT_DOOR       = 0;
  localparam int FLT_DRY_HEAT   = 1;
  localparam int FLT_VALVE_PUMP = 2;
  localparam int FLT_OVERFLOW   = 3;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'd0,
    MODE_UP   = 2'd1,
    MODE_DOWN = 2'd2
  } rate_mode_e;

  // Both requests at once cancel out and hold the value.
  function automatic rate_mode_e rate_mode(input logic up, input logic down);
    if (up && !down)      return MODE_UP;
    else if (down && !up) return MODE_DOWN;
    else                  return MODE_HOLD;
  endfunction

endpackage

// File: rtl/washer_plant_model_if.sv
// Actuator/sensor interface between the washer controller (master) and the plant (slave).
interface washer_plant_model_if #(
  parameter int LEVEL_MAX   = 20,
  parameter int TEMP_TARGET = 15,
  parameter int REV_W       = 16
);
  localparam int LW = $clog2(LEVEL_MAX + 1);
  localparam int TW = $clog2(2 * TEMP_TARGET + 1);

  logic             DOOR_LOCK;
  logic             WATER_VALVE;
  logic             DETERGENT_HATCH;
  logic             WATER_HEATER;
  logic             DRUM_MOTOR;
  logic             WATER_PUMP;
  logic             FAULT_CLR;
  logic             WATER_LEVEL_SENSOR;
  logic             TEMP_SENSOR;
  logic             DETERGENT_PRESENT;
  logic [LW-1:0]    LEVEL;
  logic [TW-1:0]    TEMP;
  logic [REV_W-1:0] DRUM_REVS;
  logic [3:0]       FAULT;

  modport master (
    output DOOR_LOCK, WATER_VALVE, DETERGENT_HATCH, WATER_HEATER, DRUM_MOTOR,
           WATER_PUMP, FAULT_CLR,
    input  WATER_LEVEL_SENSOR, TEMP_SENSOR, DETERGENT_PRESENT, LEVEL, TEMP,
           DRUM_REVS, FAULT
  );

  modport slave (
    input  DOOR_LOCK, WATER_VALVE, DETERGENT_HATCH, WATER_HEATER, DRUM_MOTOR,
           WATER_PUMP, FAULT_CLR,
    output WATER_LEVEL_SENSOR, TEMP_SENSOR, DETERGENT_PRESENT, LEVEL, TEMP,
           DRUM_REVS, FAULT
  );
endinterface

// File: rtl/washer_plant_model_rate_counter.sv
// Prescaled saturating up/down counter: one step per DIV (up) or DN_DIV (down) cycles
// spent continuously in that direction; the prescaler restarts on hold or direction change.
module plant_rate_counter
  import washer_pkg::*;
#(
  parameter int MAX    = 20,
  parameter int DIV    = 1,
  parameter int DN_DIV = DIV,
  parameter int W      = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_up,
  input  logic         i_down,
  output logic [W-1:0] o_value,
  output logic         o_dec_step
);
  localparam int PMAX = (DIV > DN_DIV) ? DIV : DN_DIV;
  localparam int PW   = $clog2(PMAX + 1);

  rate_mode_e   r_mode;
  logic [PW-1:0] r_pre;
  logic [W-1:0]  r_value;

  rate_mode_e    w_mode;
  logic [PW-1:0] w_pre_cur;
  logic [PW-1:0] w_pre_last;
  logic          w_tick;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    w_mode     = rate_mode(i_up, i_down);
    w_pre_last = (w_mode == MODE_UP) ? PW'(DIV - 1) : PW'(DN_DIV - 1);
    // A direction change restarts the count in this same cycle.
    w_pre_cur  = (w_mode != r_mode) ? '0 : r_pre;
    w_tick     = (w_mode != MODE_HOLD) && (w_pre_cur == w_pre_last);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode  <= MODE_HOLD;
      r_pre   <= '0;
      r_value <= '0;
    end else begin
      r_mode <= w_mode;
      if (w_mode == MODE_HOLD || w_tick) r_pre <= '0;
      else                               r_pre <= w_pre_cur + 1'b1;

      if (w_tick && w_mode == MODE_UP && r_value != W'(MAX))
        r_value <= r_value + 1'b1;
      else if (w_tick && w_mode == MODE_DOWN && r_value != '0)
        r_value <= r_value - 1'b1;
    end
  end

  assign o_value    = r_value;
  assign o_dec_step = w_tick && (w_mode == MODE_DOWN) && (r_value != '0);

endmodule

// File: rtl/washer_plant_model.sv
// Washer plant emulator: water level, temperature, detergent and drum activity driven by
// the controller's actuator commands. Define PLANT_FAULT_EN to build the sticky fault flags.
module washer_plant_model
  import washer_pkg::*;
#(
  parameter int LEVEL_MAX   = 20,
  parameter int FILL_DIV    = 1,
  parameter int TEMP_TARGET = 15,
  parameter int HEAT_DIV    = 2,
  parameter int COOL_DIV    = 8,
  parameter int REV_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  washer_plant_model_if.slave  bus
);
  localparam int LW = $clog2(LEVEL_MAX + 1);
  localparam int TW = $clog2(2 * TEMP_TARGET + 1);

  logic             w_fill;
  logic             w_drain;
  logic             w_heat;
  logic             w_level_dec;
  logic [LW-1:0]    w_level;
  logic [TW-1:0]    w_temp;
  logic             r_detergent;
  logic [REV_W-1:0] r_revs;

  assign w_fill  = bus.WATER_VALVE && !bus.WATER_PUMP;
  assign w_drain = bus.WATER_PUMP && !bus.WATER_VALVE;
  assign w_heat  = bus.WATER_HEATER && (w_level != '0);

  plant_rate_counter #(
    .MAX(LEVEL_MAX), .DIV(FILL_DIV), .DN_DIV(FILL_DIV), .W(LW)
  ) u_level (
    .clk(clk), .rst_n(rst_n), .i_up(w_fill), .i_down(w_drain),
    .o_value(w_level), .o_dec_step(w_level_dec)
  );

  // Cooling is the default whenever heating is not possible; it stops at 0 by saturation.
  plant_rate_counter #(
    .MAX(2 * TEMP_TARGET), .DIV(HEAT_DIV), .DN_DIV(COOL_DIV), .W(TW)
  ) u_temp (
    .clk(clk), .rst_n(rst_n), .i_up(w_heat), .i_down(!w_heat),
    .o_value(w_temp), .o_dec_step()
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_detergent <= 1'b0;
      r_revs      <= '0;
    end else begin
      if (bus.DETERGENT_HATCH)
        r_detergent <= 1'b1;
      else if (w_drain && w_level_dec && w_level == LW'(1))
        r_detergent <= 1'b0;

      if (bus.DRUM_MOTOR && r_revs != '1)
        r_revs <= r_revs + 1'b1;
    end
  end

  assign bus.LEVEL              = w_level;
  assign bus.TEMP               = w_temp;
  assign bus.DRUM_REVS          = r_revs;
  assign bus.DETERGENT_PRESENT  = r_detergent;
  assign bus.WATER_LEVEL_SENSOR = (w_level == LW'(LEVEL_MAX));
  assign bus.TEMP_SENSOR        = (w_temp >= TW'(TEMP_TARGET));

`ifdef PLANT_FAULT_EN
  logic [3:0] r_fault;
  logic [3:0] w_fault_set;

  always_comb begin
    w_fault_set                 = '0;
    w_fault_set[FLT_DOOR]       = !bus.DOOR_LOCK && (bus.WATER_VALVE || bus.WATER_HEATER ||
                                                     bus.DRUM_MOTOR  || bus.WATER_PUMP);
    w_fault_set[FLT_DRY_HEAT]   = bus.WATER_HEATER && (w_level == '0);
    w_fault_set[FLT_VALVE_PUMP] = bus.WATER_VALVE && bus.WATER_PUMP;
    w_fault_set[FLT_OVERFLOW]   = w_fill && (w_level == LW'(LEVEL_MAX));
  end

  // A condition present during the clear cycle survives the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             r_fault <= '0;
    else if (bus.FAULT_CLR) r_fault <= w_fault_set;
    else                    r_fault <= r_fault | w_fault_set;
  end

  assign bus.FAULT = r_fault;
`else
  logic w_unused_fault_inputs;
  assign w_unused_fault_inputs = &{1'b0, bus.DOOR_LOCK, bus.FAULT_CLR};
  assign bus.FAULT = 4'b0000;
`endif

endmodule

// File: tb/tb_washer_plant_model.sv
// Directed self-checking bench for washer_plant_model with default parameters;
// fault expectations follow whether PLANT_FAULT_EN is defined.
module tb_washer_plant_model;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  washer_plant_model_if bus ();

  washer_plant_model dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] exp_fault(input logic [3:0] f);
`ifdef PLANT_FAULT_EN
    return f;
`else
    return 4'b0000 & f;
`endif
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.DOOR_LOCK       = 1'b0;
    bus.WATER_VALVE     = 1'b0;
    bus.DETERGENT_HATCH = 1'b0;
    bus.WATER_HEATER    = 1'b0;
    bus.DRUM_MOTOR      = 1'b0;
    bus.WATER_PUMP      = 1'b0;
    bus.FAULT_CLR       = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (bus.LEVEL !== 5'd0 || bus.TEMP !== 5'd0 || bus.DRUM_REVS !== 16'd0 ||
        bus.DETERGENT_PRESENT !== 1'b0 || bus.FAULT !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_state: level=%0d temp=%0d revs=%0d det=%b fault=%b, required all zero",
               bus.LEVEL, bus.TEMP, bus.DRUM_REVS, bus.DETERGENT_PRESENT, bus.FAULT);
    end
    n_checks++;
    if (bus.WATER_LEVEL_SENSOR !== 1'b0 || bus.TEMP_SENSOR !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_sensors: wls=%b ts=%b, required 0 0",
               bus.WATER_LEVEL_SENSOR, bus.TEMP_SENSOR);
    end
  endtask

  task automatic test_fill();
    apply_reset();
    bus.DOOR_LOCK   = 1'b1;
    bus.WATER_VALVE = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      n_checks++;
      if (bus.LEVEL !== 5'(k)) begin
        n_fail++;
        $display("FAIL fill_level edge %0d: got %0d, required %0d", k, bus.LEVEL, k);
      end
      n_checks++;
      if (bus.WATER_LEVEL_SENSOR !== (k == 20)) begin
        n_fail++;
        $display("FAIL fill_sensor edge %0d: got %b, required %b", k,
                 bus.WATER_LEVEL_SENSOR, (k == 20));
      end
    end
    step(1);
    n_checks++;
    if (bus.LEVEL !== 5'd20) begin
      n_fail++;
      $display("FAIL fill_saturate: got %0d, required 20", bus.LEVEL);
    end
    n_checks++;
    if (bus.FAULT !== exp_fault(4'b1000)) begin
      n_fail++;
      $display("FAIL fill_overflow_fault: got %b, required %b", bus.FAULT, exp_fault(4'b1000));
    end
  endtask

  task automatic test_heat();
    apply_reset();
    bus.DOOR_LOCK   = 1'b1;
    bus.WATER_VALVE = 1'b1;
    step(20);
    bus.WATER_VALVE  = 1'b0;
    bus.WATER_HEATER = 1'b1;
    step(29);
    n_checks++;
    if (bus.TEMP !== 5'd14 || bus.TEMP_SENSOR !== 1'b0) begin
      n_fail++;
      $display("FAIL heat_29: temp=%0d ts=%b, required 14 0", bus.TEMP, bus.TEMP_SENSOR);
    end
    step(1);
    n_checks++;
    if (bus.TEMP !== 5'd15 || bus.TEMP_SENSOR !== 1'b1) begin
      n_fail++;
      $display("FAIL heat_30: temp=%0d ts=%b, required 15 1", bus.TEMP, bus.TEMP_SENSOR);
    end
    bus.WATER_HEATER = 1'b0;
    step(7);
    n_checks++;
    if (bus.TEMP !== 5'd15) begin
      n_fail++;
      $display("FAIL cool_7: temp=%0d, required 15", bus.TEMP);
    end
    step(1);
    n_checks++;
    if (bus.TEMP !== 5'd14 || bus.TEMP_SENSOR !== 1'b0) begin
      n_fail++;
      $display("FAIL cool_8: temp=%0d ts=%b, required 14 0", bus.TEMP, bus.TEMP_SENSOR);
    end
    n_checks++;
    if (bus.LEVEL !== 5'd20) begin
      n_fail++;
      $display("FAIL heat_level_hold: got %0d, required 20", bus.LEVEL);
    end
  endtask

  task automatic test_dry_heat();
    apply_reset();
    bus.DOOR_LOCK    = 1'b1;
    bus.WATER_HEATER = 1'b1;
    step(50);
    n_checks++;
    if (bus.TEMP !== 5'd0) begin
      n_fail++;
      $display("FAIL dry_heat_temp: got %0d, required 0", bus.TEMP);
    end
    n_checks++;
    if (bus.FAULT !== exp_fault(4'b0010)) begin
      n_fail++;
      $display("FAIL dry_heat_fault: got %b, required %b", bus.FAULT, exp_fault(4'b0010));
    end
    bus.WATER_HEATER = 1'b0;
    bus.FAULT_CLR    = 1'b1;
    step(1);
    bus.FAULT_CLR = 1'b0;
    n_checks++;
    if (bus.FAULT !== 4'b0000) begin
      n_fail++;
      $display("FAIL fault_clear: got %b, required 0000", bus.FAULT);
    end
    bus.WATER_HEATER = 1'b1;
    bus.FAULT_CLR    = 1'b1;
    step(1);
    bus.FAULT_CLR    = 1'b0;
    bus.WATER_HEATER = 1'b0;
    n_checks++;
    if (bus.FAULT !== exp_fault(4'b0010)) begin
      n_fail++;
      $display("FAIL set_beats_clear: got %b, required %b", bus.FAULT, exp_fault(4'b0010));
    end
  endtask

  task automatic test_drain_detergent();
    apply_reset();
    bus.DOOR_LOCK       = 1'b1;
    bus.WATER_VALVE     = 1'b1;
    bus.DETERGENT_HATCH = 1'b1;
    step(1);
    bus.DETERGENT_HATCH = 1'b0;
    step(19);
    n_checks++;
    if (bus.LEVEL !== 5'd20 || bus.DETERGENT_PRESENT !== 1'b1) begin
      n_fail++;
      $display("FAIL detergent_after_fill: level=%0d det=%b, required 20 1",
               bus.LEVEL, bus.DETERGENT_PRESENT);
    end
    bus.WATER_VALVE = 1'b0;
    bus.WATER_PUMP  = 1'b1;
    step(19);
    n_checks++;
    if (bus.LEVEL !== 5'd1 || bus.DETERGENT_PRESENT !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_19: level=%0d det=%b, required 1 1", bus.LEVEL, bus.DETERGENT_PRESENT);
    end
    step(1);
    n_checks++;
    if (bus.LEVEL !== 5'd0 || bus.DETERGENT_PRESENT !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_20: level=%0d det=%b, required 0 0", bus.LEVEL, bus.DETERGENT_PRESENT);
    end
    step(2);
    n_checks++;
    if (bus.LEVEL !== 5'd0) begin
      n_fail++;
      $display("FAIL drain_saturate: got %0d, required 0", bus.LEVEL);
    end
  endtask

  task automatic test_simultaneous_door();
    apply_reset();
    bus.DOOR_LOCK   = 1'b1;
    bus.WATER_VALVE = 1'b1;
    step(5);
    bus.DOOR_LOCK  = 1'b0;
    bus.WATER_PUMP = 1'b1;
    step(5);
    n_checks++;
    if (bus.LEVEL !== 5'd5) begin
      n_fail++;
      $display("FAIL valve_pump_hold: got %0d, required 5", bus.LEVEL);
    end
    n_checks++;
    if (bus.FAULT !== exp_fault(4'b0101)) begin
      n_fail++;
      $display("FAIL door_valve_pump_fault: got %b, required %b", bus.FAULT, exp_fault(4'b0101));
    end
    bus.WATER_VALVE = 1'b0;
    bus.WATER_PUMP  = 1'b0;
    bus.DRUM_MOTOR  = 1'b1;
    step(10);
    bus.DRUM_MOTOR = 1'b0;
    step(3);
    n_checks++;
    if (bus.DRUM_REVS !== 16'd10) begin
      n_fail++;
      $display("FAIL drum_revs: got %0d, required 10", bus.DRUM_REVS);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    bus.DOOR_LOCK       = 1'b1;
    bus.WATER_VALVE     = 1'b1;
    bus.DRUM_MOTOR      = 1'b1;
    bus.DETERGENT_HATCH = 1'b1;
    step(7);
    bus.DETERGENT_HATCH = 1'b0;
    n_checks++;
    if (bus.LEVEL !== 5'd7 || bus.DRUM_REVS !== 16'd7 || bus.DETERGENT_PRESENT !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset: level=%0d revs=%0d det=%b, required 7 7 1",
               bus.LEVEL, bus.DRUM_REVS, bus.DETERGENT_PRESENT);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.LEVEL !== 5'd0 || bus.TEMP !== 5'd0 || bus.DRUM_REVS !== 16'd0 ||
        bus.DETERGENT_PRESENT !== 1'b0 || bus.FAULT !== 4'b0000) begin
      n_fail++;
      $display("FAIL async_reset: level=%0d temp=%0d revs=%0d det=%b fault=%b, required all zero",
               bus.LEVEL, bus.TEMP, bus.DRUM_REVS, bus.DETERGENT_PRESENT, bus.FAULT);
    end
    bus.DRUM_MOTOR = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(3);
    n_checks++;
    if (bus.LEVEL !== 5'd3) begin
      n_fail++;
      $display("FAIL refill_after_reset: got %0d, required 3", bus.LEVEL);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b1;
    idle_inputs();
    test_reset();
    test_fill();
    test_heat();
    test_dry_heat();
    test_drain_detergent();
    test_simultaneous_door();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
